// File: rtl/fetch_stage_pkg.sv
// Shared fetch-side definitions: fetch FSM states and architectural PC/NOP constants
// reused by the hazard and exception logic.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] FETCH_EXC_VECTOR = 32'h0000_0180;
  localparam logic [31:0] FETCH_NOP_INSTR  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding req/gnt/rvalid transaction feeding the IF/ID
// register; honours decode stall and redirects on branch or exception.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = FETCH_EXC_VECTOR,
  parameter logic [31:0] NOP_INSTR  = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        except_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] PCplus4,
  output logic        id_valid,
  output logic [31:0] pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;
  logic         req_q, req_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         deliver;
  logic [31:0]  deliver_word;

  assign redirect = except_valid | branch_taken;
  assign target   = except_valid ? EXC_VECTOR : word_align(branch_target);
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    instr_d      = instr_q;
    pcp4_d       = pcp4_q;
    valid_d      = valid_q;
    drop_d       = drop_q;
    deliver      = 1'b0;
    deliver_word = buf_q;

    case (state_q)
      FS_REQ: begin
        // req_q is low only in the first cycle after reset, so a gnt there is not a handshake
        if (req_q && imem_gnt) begin
          state_d = FS_WAIT;
          drop_d  = redirect;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (drop_q || redirect) begin
            state_d = FS_REQ;
          end else if (!stall) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            state_d      = FS_REQ;
          end else begin
            buf_d   = imem_rdata;
            state_d = FS_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          state_d = FS_REQ;
        end else if (!stall) begin
          deliver = 1'b1;
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase

    if (redirect) begin
      pc_d = target;
    end else if (deliver) begin
      pc_d = pc_plus4;
    end

    // Flush beats stall; a stall without a delivery freezes IF/ID including id_valid
    if (redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (deliver) begin
      valid_d = 1'b1;
      instr_d = deliver_word;
      pcp4_d  = pc_plus4;
    end else if (!stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    req_d = (state_d == FS_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      instr_q <= NOP_INSTR;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign PCplus4   = pcp4_q;
  assign id_valid  = valid_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, all checked against
// a transaction-level model of the fetch stage and a behavioural instruction memory.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        except_valid = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] PCplus4;
  logic        id_valid;
  logic [31:0] pc;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0180),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .except_valid (except_valid),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .PCplus4      (PCplus4),
    .id_valid     (id_valid),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a fetch is either idle (requesting), outstanding (possibly stale), or parked
  bit          m_started, m_out, m_stale, m_held, m_v;
  logic [31:0] m_pc, m_held_word, m_instr, m_p4;

  bit          mem_pend;
  logic [31:0] mem_addr;
  int unsigned mem_dly;

  bit          k_gnt, k_spur, k_force_rv;
  int unsigned k_lat, k_lat_min;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h0109_5020;
      32'hC:   return 32'h8C0A_0004;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_out = 0; m_stale = 0; m_held = 0; m_v = 0;
    m_pc = 32'h0; m_held_word = '0; m_instr = 32'h0; m_p4 = 32'h0;
    mem_pend = 0; mem_dly = 0;
  endtask

  function automatic bit model_req();
    return m_started && !m_out && !m_held;
  endfunction

  task automatic model_step();
    bit          redirect, delivered;
    logic [31:0] tgt, word, old_pc;
    bit          req_vis;
    redirect  = except_valid || branch_taken;
    tgt       = except_valid ? 32'h0000_0180 : (branch_target & 32'hFFFF_FFFC);
    req_vis   = model_req();
    old_pc    = m_pc;
    delivered = 0;
    word      = '0;

    if (mem_pend) begin
      if (mem_dly == 0 && imem_rvalid) mem_pend = 0;
      else if (mem_dly > 0) mem_dly--;
    end

    if (req_vis && imem_gnt) begin
      m_out    = 1;
      m_stale  = redirect;
      mem_pend = 1;
      mem_addr = old_pc;
      mem_dly  = $urandom_range(k_lat, k_lat_min);
    end else if (m_out && imem_rvalid) begin
      m_out = 0;
      if (!m_stale && !redirect) begin
        if (!stall) begin
          delivered = 1; word = imem_rdata;
        end else begin
          m_held = 1; m_held_word = imem_rdata;
        end
      end
      m_stale = 0;
    end else if (m_out && redirect) begin
      m_stale = 1;
    end else if (m_held && (redirect || !stall)) begin
      if (!redirect) begin
        delivered = 1; word = m_held_word;
      end
      m_held = 0;
    end

    if (redirect) m_pc = tgt;
    else if (delivered) m_pc = old_pc + 32'd4;

    if (redirect) begin
      m_v = 0; m_instr = 32'h0;
    end else if (delivered) begin
      m_v = 1; m_instr = word; m_p4 = old_pc + 32'd4;
    end else if (!stall) begin
      m_v = 0; m_instr = 32'h0;
    end
    m_started = 1;
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(model_req()));
    if (model_req()) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_v));
    chk("instr", instr, m_instr);
    if (m_v) chk("PCplus4", PCplus4, m_p4);
  endtask

  task automatic cycle();
    imem_gnt = k_gnt;
    if (mem_pend && mem_dly == 0) begin
      imem_rvalid = 1; imem_rdata = memword(mem_addr);
    end else if (!mem_pend && (k_force_rv || (k_spur && $urandom_range(5) == 0))) begin
      imem_rvalid = 1; imem_rdata = $urandom;
    end else begin
      imem_rvalid = 0; imem_rdata = $urandom;
    end
    @(posedge clk);
    model_step();
    #1 compare();
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst_n = 0;
    imem_gnt = 1; imem_rvalid = 1; imem_rdata = $urandom;
    model_reset();
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_p4", PCplus4, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    imem_rvalid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    k_gnt = 1; k_lat = 0; k_lat_min = 0; k_spur = 0; k_force_rv = 0;
    model_reset();
    do_reset(2);

    // Zero-wait memory: one instruction every two cycles
    repeat (3) cycle();
    chk("zw_v0", 32'(id_valid), 32'h1);
    chk("zw_p4_0", PCplus4, 32'h4);
    chk("zw_i0", instr, 32'h2008_0001);
    repeat (2) cycle();
    chk("zw_p4_1", PCplus4, 32'h8);
    chk("zw_i1", instr, 32'h2009_0002);
    repeat (2) cycle();
    chk("zw_pc", pc, 32'hC);
    chk("zw_p4_2", PCplus4, 32'hC);
    chk("zw_i2", instr, 32'h0109_5020);

    // Stall across response arrival: response parked, IF/ID frozen
    stall = 1;
    cycle();
    chk("st_v_a", 32'(id_valid), 32'h1);
    cycle();
    chk("st_req_b", 32'(imem_req), 32'h0);
    chk("st_i_b", instr, 32'h0109_5020);
    cycle();
    chk("st_req_c", 32'(imem_req), 32'h0);
    chk("st_v_c", 32'(id_valid), 32'h1);
    stall = 0;
    cycle();
    chk("st_rel_i", instr, 32'h8C0A_0004);
    chk("st_rel_p4", PCplus4, 32'h10);

    // Branch coincident with gnt: old response dropped
    branch_taken = 1; branch_target = 32'h40;
    cycle();
    branch_taken = 0;
    chk("br_v", 32'(id_valid), 32'h0);
    chk("br_pc", pc, 32'h40);
    cycle();
    chk("br_req", 32'(imem_req), 32'h1);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_v2", 32'(id_valid), 32'h0);
    repeat (2) cycle();
    chk("br_p4", PCplus4, 32'h44);

    // Exception outranks branch
    k_gnt = 0; except_valid = 1; branch_taken = 1; branch_target = 32'h100;
    cycle();
    except_valid = 0; branch_taken = 0;
    chk("exc_addr", imem_addr, 32'h180);

    // Wraparound of PC and PCplus4
    branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    cycle();
    branch_taken = 0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    k_gnt = 1;
    repeat (2) cycle();
    chk("wr_p4", PCplus4, 32'h0);
    chk("wr_addr0", imem_addr, 32'h0);

    // Reset while a response is outstanding
    k_lat = 6; k_lat_min = 4;
    cycle();
    chk("rm_wait_req", 32'(imem_req), 32'h0);
    do_reset(2);
    k_lat = 0; k_lat_min = 0; k_force_rv = 1;
    cycle();
    k_force_rv = 0;
    chk("rm_req", 32'(imem_req), 32'h1);
    chk("rm_addr", imem_addr, 32'h0);

    // Randomized traffic
    k_spur = 1;
    for (int i = 0; i < 4000; i++) begin
      stall         = ($urandom_range(2) == 0);
      branch_taken  = ($urandom_range(9) == 0);
      except_valid  = ($urandom_range(24) == 0);
      branch_target = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                               : ($urandom & 32'h0000_0FFF);
      k_gnt         = ($urandom_range(2) != 0);
      k_lat         = $urandom_range(3);
      if ($urandom_range(499) == 0) do_reset(1 + $urandom_range(1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
